// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run-control unit between the system clock/reset and a monocycle core.
//
// The core is gated by a clock enable and its reset is driven from here. Commands give
// free-run, N-step and halt, plus a PC breakpoint. The unit also keeps saturating cycle and
// retired-instruction counters and a circular trace of the last TRACE_DEPTH executed
// (pc, instruction) pairs.
//
// Ports:
//   clk_i, rst_ni            system clock (rising edge), asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o  command handshake; cmd_op_i 00 HALT, 01 RUN, 10 STEP, 11 CLEAR
//   cmd_steps_i              step count for STEP
//   bp_en_i, bp_addr_i       PC breakpoint
//   cpu_pc_i, cpu_instruction_i  core's current PC and instruction
//   cpu_rst_n_o, cpu_ce_o    core reset (active-low) and clock enable
//   state_o                  00 RST_HOLD, 01 HALT, 10 RUN, 11 STEP
//   halted_on_bp_o           last halt was caused by the breakpoint
//   cycle_count_o            cycles spent outside RST_HOLD, saturating
//   retired_count_o          edges with cpu_ce_o=1, saturating
//   trace_rd_i               pop oldest trace entry
//   trace_pc_o, trace_instr_o  oldest trace entry, 0 when empty
//   trace_empty_o, trace_full_o, trace_overflow_o  trace status (overflow is sticky)
//
// TRACE_DEPTH must be a power of two, at least 2. RESET_CYCLES must be at least 1.

module cpu_run_ctrl #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned TRACE_DEPTH  = 8,
    parameter int unsigned RESET_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [CNT_W-1:0] cmd_steps_i,

    input  logic             bp_en_i,
    input  logic [XLEN-1:0]  bp_addr_i,

    input  logic [XLEN-1:0]  cpu_pc_i,
    input  logic [XLEN-1:0]  cpu_instruction_i,
    output logic             cpu_rst_n_o,
    output logic             cpu_ce_o,

    output logic [1:0]       state_o,
    output logic             halted_on_bp_o,
    output logic [CNT_W-1:0] cycle_count_o,
    output logic [CNT_W-1:0] retired_count_o,

    input  logic             trace_rd_i,
    output logic [XLEN-1:0]  trace_pc_o,
    output logic [XLEN-1:0]  trace_instr_o,
    output logic             trace_empty_o,
    output logic             trace_full_o,
    output logic             trace_overflow_o
);

    localparam int unsigned PtrW   = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam int unsigned TCntW  = PtrW + 1;
    localparam int unsigned HoldW  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [HoldW-1:0] HoldLast    = HoldW'(RESET_CYCLES - 1);
    localparam logic [TCntW-1:0] TraceDepthC = TCntW'(TRACE_DEPTH);

    localparam logic [1:0] OpHalt  = 2'b00;
    localparam logic [1:0] OpRun   = 2'b01;
    localparam logic [1:0] OpStep  = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    typedef enum logic [1:0] {
        StRstHold = 2'b00,
        StHalt    = 2'b01,
        StRun     = 2'b10,
        StStep    = 2'b11
    } state_e;

    // ---------------------------------------------------------------------------------------
    // Control state
    // ---------------------------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             skip_bp_q, skip_bp_d;
    logic             halted_on_bp_q, halted_on_bp_d;
    logic             cpu_rst_n_q;

    logic             cmd_ready;
    logic             cmd_fire;
    logic             clear;
    logic             bp_hit;
    logic             cpu_ce;

    assign cmd_fire = cmd_valid_i && cmd_ready;
    assign clear    = cmd_fire && (cmd_op_i == OpClear);
    // skip_bp lets a RUN issued while parked on the breakpoint execute that instruction.
    assign bp_hit   = bp_en_i && (cpu_pc_i == bp_addr_i) && !skip_bp_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StRstHold;
            hold_q         <= '0;
            remaining_q    <= '0;
            skip_bp_q      <= 1'b0;
            halted_on_bp_q <= 1'b0;
            cpu_rst_n_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            remaining_q    <= remaining_d;
            skip_bp_q      <= skip_bp_d;
            halted_on_bp_q <= halted_on_bp_d;
            // Registered so core reset releases on the same edge that enters HALT.
            cpu_rst_n_q    <= (state_d != StRstHold);
        end
    end

    // Next-state logic
    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        remaining_d    = remaining_q;
        skip_bp_d      = skip_bp_q;
        halted_on_bp_d = halted_on_bp_q;

        unique case (state_q)
            StRstHold: begin
                if (hold_q == HoldLast) begin
                    state_d = StHalt;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            StHalt: begin
            end
            StRun: begin
                skip_bp_d = 1'b0;
                if (bp_hit) begin
                    state_d        = StHalt;
                    halted_on_bp_d = 1'b1;
                end
            end
            StStep: begin
                if (remaining_q <= CNT_W'(1)) begin
                    state_d     = StHalt;
                    remaining_d = '0;
                end else begin
                    remaining_d = remaining_q - CNT_W'(1);
                end
            end
        endcase

        // An accepted command overrides the activity above on the same edge.
        if (cmd_fire) begin
            unique case (cmd_op_i)
                OpHalt: begin
                    state_d        = StHalt;
                    halted_on_bp_d = 1'b0;
                    skip_bp_d      = 1'b0;
                    remaining_d    = '0;
                end
                OpRun: begin
                    state_d        = StRun;
                    halted_on_bp_d = 1'b0;
                    skip_bp_d      = 1'b1;
                    remaining_d    = '0;
                end
                OpStep: begin
                    // Zero steps is a no-op: the current activity carries on untouched.
                    if (cmd_steps_i != '0) begin
                        state_d        = StStep;
                        remaining_d    = cmd_steps_i;
                        halted_on_bp_d = 1'b0;
                        skip_bp_d      = 1'b0;
                    end
                end
                OpClear: begin
                    state_d        = StRstHold;
                    hold_d         = '0;
                    halted_on_bp_d = 1'b0;
                    skip_bp_d      = 1'b0;
                    remaining_d    = '0;
                end
            endcase
        end
    end

    // Output logic: no combinational path from cmd_* to cpu_ce.
    always_comb begin
        cpu_ce    = 1'b0;
        cmd_ready = 1'b1;
        unique case (state_q)
            StRstHold: cmd_ready = 1'b0;
            StHalt:    cpu_ce    = 1'b0;
            StRun:     cpu_ce    = !bp_hit;
            StStep:    cpu_ce    = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------------------------------
    // Cycle and retired counters
    // ---------------------------------------------------------------------------------------
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    always_comb begin
        cycle_d   = cycle_q;
        retired_d = retired_q;
        if (clear) begin
            cycle_d   = '0;
            retired_d = '0;
        end else begin
            if ((state_q != StRstHold) && (cycle_q != '1)) begin
                cycle_d = cycle_q + CNT_W'(1);
            end
            if (cpu_ce && (retired_q != '1)) begin
                retired_d = retired_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            retired_q <= retired_d;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Trace buffer
    // ---------------------------------------------------------------------------------------
    logic [2*XLEN-1:0] mem_q [TRACE_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [TCntW-1:0]  tcount_q, tcount_d;
    logic              overflow_q, overflow_d;
    logic              trace_empty;
    logic              trace_full;
    logic              trace_we;
    logic              trace_re;
    logic [2*XLEN-1:0] rd_entry;

    assign trace_empty = (tcount_q == '0);
    assign trace_full  = (tcount_q == TraceDepthC);
    assign trace_we    = cpu_ce;
    assign trace_re    = trace_rd_i && !trace_empty;

    // Pointers wrap for free since TRACE_DEPTH is a power of two.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tcount_d   = tcount_q;
        overflow_d = overflow_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            tcount_d   = '0;
            overflow_d = 1'b0;
        end else if (trace_we && trace_re) begin
            // Pop and push together: the popped slot absorbs the new entry, no overflow.
            wr_ptr_d = wr_ptr_q + PtrW'(1);
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end else if (trace_we) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (trace_full) begin
                rd_ptr_d   = rd_ptr_q + PtrW'(1);
                overflow_d = 1'b1;
            end else begin
                tcount_d = tcount_q + TCntW'(1);
            end
        end else if (trace_re) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
            tcount_d = tcount_q - TCntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tcount_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tcount_q   <= tcount_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage has no reset; entries are only visible through the count.
    always_ff @(posedge clk_i) begin
        if (trace_we) begin
            mem_q[wr_ptr_q] <= {cpu_pc_i, cpu_instruction_i};
        end
    end

    assign rd_entry = mem_q[rd_ptr_q];

    // ---------------------------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------------------------
    assign cmd_ready_o      = cmd_ready;
    assign cpu_ce_o         = cpu_ce;
    assign cpu_rst_n_o      = cpu_rst_n_q;
    assign state_o          = state_q;
    assign halted_on_bp_o   = halted_on_bp_q;
    assign cycle_count_o    = cycle_q;
    assign retired_count_o  = retired_q;
    assign trace_pc_o       = trace_empty ? '0 : rd_entry[2*XLEN-1:XLEN];
    assign trace_instr_o    = trace_empty ? '0 : rd_entry[XLEN-1:0];
    assign trace_empty_o    = trace_empty;
    assign trace_full_o     = trace_full;
    assign trace_overflow_o = overflow_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl. A tiny core model advances its PC by 4 on every
// enabled edge; expected trace PCs are queued when stimulus is issued and compared on pop.

module tb_cpu_run_ctrl;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned CNT_W        = 32;
    localparam int unsigned TRACE_DEPTH  = 8;
    localparam int unsigned RESET_CYCLES = 2;

    localparam logic [1:0] OP_HALT  = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [1:0] ST_RST  = 2'b00;
    localparam logic [1:0] ST_HALT = 2'b01;
    localparam logic [1:0] ST_RUN  = 2'b10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [CNT_W-1:0] cmd_steps = '0;
    logic             bp_en = 1'b0;
    logic [XLEN-1:0]  bp_addr = '0;
    logic [XLEN-1:0]  core_pc = '0;
    logic [XLEN-1:0]  cpu_instruction;
    logic             cpu_rst_n;
    logic             cpu_ce;
    logic [1:0]       state;
    logic             halted_on_bp;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retired_count;
    logic             trace_rd = 1'b0;
    logic [XLEN-1:0]  trace_pc;
    logic [XLEN-1:0]  trace_instr;
    logic             trace_empty;
    logic             trace_full;
    logic             trace_overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [XLEN-1:0] exp_q [$];

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] instr_of(input logic [XLEN-1:0] pc);
        return (pc * 32'h0001_0003) ^ 32'h0000_0013;
    endfunction

    assign cpu_instruction = instr_of(core_pc);

    // Core model: commits only when enabled, held at PC 0 while in reset.
    always @(posedge clk) begin
        if (!cpu_rst_n)  core_pc <= '0;
        else if (cpu_ce) core_pc <= core_pc + 32'd4;
    end

    cpu_run_ctrl #(
        .XLEN         (XLEN),
        .CNT_W        (CNT_W),
        .TRACE_DEPTH  (TRACE_DEPTH),
        .RESET_CYCLES (RESET_CYCLES)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .cmd_valid_i       (cmd_valid),
        .cmd_ready_o       (cmd_ready),
        .cmd_op_i          (cmd_op),
        .cmd_steps_i       (cmd_steps),
        .bp_en_i           (bp_en),
        .bp_addr_i         (bp_addr),
        .cpu_pc_i          (core_pc),
        .cpu_instruction_i (cpu_instruction),
        .cpu_rst_n_o       (cpu_rst_n),
        .cpu_ce_o          (cpu_ce),
        .state_o           (state),
        .halted_on_bp_o    (halted_on_bp),
        .cycle_count_o     (cycle_count),
        .retired_count_o   (retired_count),
        .trace_rd_i        (trace_rd),
        .trace_pc_o        (trace_pc),
        .trace_instr_o     (trace_instr),
        .trace_empty_o     (trace_empty),
        .trace_full_o      (trace_full),
        .trace_overflow_o  (trace_overflow)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [CNT_W-1:0] steps);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check_eq("cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_steps = steps;
        tick();
        cmd_valid = 1'b0;
        cmd_steps = '0;
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget, input string tag);
        int n = 0;
        while (state !== st && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, state, st);
    endtask

    task automatic push_pcs(input logic [XLEN-1:0] first, input int count);
        for (int i = 0; i < count; i++) exp_q.push_back(first + 32'(4 * i));
    endtask

    task automatic drain_and_check(input string tag);
        logic [XLEN-1:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq({tag, "_pc"}, trace_pc, e);
            check_eq({tag, "_instr"}, trace_instr, instr_of(e));
            trace_rd = 1'b1;
            tick();
            trace_rd = 1'b0;
        end
        check_eq({tag, "_empty"}, trace_empty, 1);
    endtask

    task automatic do_clear();
        send_cmd(OP_CLEAR, '0);
        check_eq("clr_state", state, ST_RST);
        check_eq("clr_rst0", cpu_rst_n, 0);
        check_eq("clr_cycles", cycle_count, 0);
        check_eq("clr_retired", retired_count, 0);
        check_eq("clr_empty", trace_empty, 1);
        check_eq("clr_ovf", trace_overflow, 0);
        check_eq("clr_hbp", halted_on_bp, 0);
        tick();
        check_eq("clr_rst1", cpu_rst_n, 0);
        tick();
        check_eq("clr_rel", cpu_rst_n, 1);
        check_eq("clr_halt", state, ST_HALT);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ce_cnt;
        logic first_ce;

        // Reset held for three edges.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_state", state, ST_RST);
        check_eq("rst_cpu_rst", cpu_rst_n, 0);
        check_eq("rst_ce", cpu_ce, 0);
        check_eq("rst_ready", cmd_ready, 0);
        check_eq("rst_empty", trace_empty, 1);
        #2;
        rst_n = 1'b1;
        tick();
        check_eq("hold1_rst", cpu_rst_n, 0);
        check_eq("hold1_state", state, ST_RST);
        tick();
        check_eq("rel_rst", cpu_rst_n, 1);
        check_eq("rel_state", state, ST_HALT);
        check_eq("rel_cycles", cycle_count, 0);
        check_eq("rel_ce", cpu_ce, 0);
        check_eq("rel_empty", trace_empty, 1);
        repeat (3) tick();
        check_eq("cycles3", cycle_count, 3);
        check_eq("retired0", retired_count, 0);

        // STEP with zero steps is a no-op.
        send_cmd(OP_STEP, 0);
        check_eq("step0_state", state, ST_HALT);
        check_eq("step0_ce", cpu_ce, 0);

        // STEP 3.
        push_pcs(32'h0, 3);
        send_cmd(OP_STEP, 3);
        first_ce = cpu_ce;
        ce_cnt   = 0;
        for (int i = 0; i < 6; i++) begin
            if (cpu_ce) ce_cnt++;
            tick();
        end
        check_eq("step3_first_ce", first_ce, 1);
        check_eq("step3_ce_cnt", 64'(ce_cnt), 3);
        check_eq("step3_retired", retired_count, 3);
        check_eq("step3_state", state, ST_HALT);
        check_eq("step3_pc", core_pc, 32'hC);
        drain_and_check("step3");
        trace_rd = 1'b1;
        tick();
        trace_rd = 1'b0;
        check_eq("rd_when_empty", trace_empty, 1);

        // Breakpoint at 0x10.
        do_clear();
        check_eq("clr_core_pc", core_pc, 0);
        bp_en   = 1'b1;
        bp_addr = 32'h10;
        push_pcs(32'h0, 4);
        send_cmd(OP_RUN, '0);
        wait_state(ST_HALT, 40, "bp_halt");
        check_eq("bp_pc", core_pc, 32'h10);
        check_eq("bp_flag", halted_on_bp, 1);
        check_eq("bp_retired", retired_count, 4);
        check_eq("bp_ce", cpu_ce, 0);
        drain_and_check("bp");

        // Resume past the breakpoint.
        send_cmd(OP_RUN, '0);
        check_eq("resume_flag", halted_on_bp, 0);
        check_eq("resume_ce", cpu_ce, 1);
        tick();
        check_eq("resume_pc14", core_pc, 32'h14);
        repeat (3) tick();
        check_eq("resume_state", state, ST_RUN);
        check_eq("resume_pc20", core_pc, 32'h20);

        // CLEAR while running.
        do_clear();
        bp_en = 1'b0;

        // Overflow: STEP 10 into an 8-entry trace.
        push_pcs(32'h8, 8);
        send_cmd(OP_STEP, 10);
        wait_state(ST_HALT, 30, "ovf_halt");
        check_eq("ovf_full", trace_full, 1);
        check_eq("ovf_flag", trace_overflow, 1);
        check_eq("ovf_retired", retired_count, 10);
        drain_and_check("ovf");
        check_eq("ovf_sticky", trace_overflow, 1);

        // Simultaneous read/write on a full trace.
        do_clear();
        send_cmd(OP_STEP, 8);
        wait_state(ST_HALT, 30, "rw_fill_halt");
        check_eq("rw_fill_full", trace_full, 1);
        check_eq("rw_fill_ovf", trace_overflow, 0);
        push_pcs(32'h20, 8);
        send_cmd(OP_STEP, 8);
        trace_rd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq("rw_full", trace_full, 1);
            tick();
        end
        trace_rd = 1'b0;
        check_eq("rw_state", state, ST_HALT);
        check_eq("rw_full_end", trace_full, 1);
        check_eq("rw_ovf", trace_overflow, 0);
        check_eq("rw_retired", retired_count, 16);
        drain_and_check("rw");

        // Asynchronous reset mid-STEP.
        send_cmd(OP_STEP, 5);
        tick();
        check_eq("areset_pre_ce", cpu_ce, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("areset_ce", cpu_ce, 0);
        check_eq("areset_state", state, ST_RST);
        check_eq("areset_cpu_rst", cpu_rst_n, 0);
        check_eq("areset_retired", retired_count, 0);
        check_eq("areset_empty", trace_empty, 1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_state(ST_HALT, 10, "areset_halt");
        check_eq("areset_cycles", cycle_count, 0);
        check_eq("areset_rel", cpu_rst_n, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Synthesizable run-control unit that sits between the system clock/reset and the monocycle core.
- Gates the core with a clock enable and drives its reset.
- Supports free-run, N-step and halt, plus a PC breakpoint.
- Counts cycles and retired instructions, and keeps a circular trace of the last TRACE_DEPTH executed (pc, instruction) pairs.
- Replaces hand-toggled clock stepping with parametrised, command-driven control.

Parameters:
- XLEN, 32, width of PC and instruction.
- CNT_W, 32, width of step count, cycle and retired counters.
- TRACE_DEPTH, 8, trace entries; power of two, at least 2.
- RESET_CYCLES, 2, cycles the core reset is held after a reset or clear; at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command strobe.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  command: 00 HALT, 01 RUN, 10 STEP, 11 CLEAR.
- cmd_steps  in  CNT_W  step count for STEP.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  XLEN  breakpoint PC.
- cpu_pc  in  XLEN  core's current PC.
- cpu_instruction  in  XLEN  core's current instruction.
- cpu_rst_n  out  1  core reset, active-low.
- cpu_ce  out  1  core clock enable; the core commits on a rising edge only when this is 1.
- state  out  2  00 RST_HOLD, 01 HALT, 10 RUN, 11 STEP.
- halted_on_bp  out  1  last halt was caused by the breakpoint.
- cycle_count  out  CNT_W  cycles since leaving RST_HOLD, saturating.
- retired_count  out  CNT_W  edges with cpu_ce=1, saturating.
- trace_rd  in  1  pop oldest trace entry.
- trace_pc  out  XLEN  oldest entry PC; 0 when empty.
- trace_instr  out  XLEN  oldest entry instruction; 0 when empty.
- trace_empty  out  1  no trace entries.
- trace_full  out  1  TRACE_DEPTH entries held.
- trace_overflow  out  1  sticky: an entry was overwritten.

Behaviour:
- Reset (rst_n=0), asynchronous:
  - state=RST_HOLD, hold counter=0, cpu_rst_n=0, cpu_ce=0, cmd_ready=0.
  - Counters 0, trace empty, trace_overflow=0, halted_on_bp=0, remaining steps=0.
- RST_HOLD:
  - cpu_rst_n=0, cpu_ce=0, cmd_ready=0.
  - After RESET_CYCLES rising edges with rst_n=1, go to HALT. cpu_rst_n goes to 1 in the same cycle state becomes HALT.
- HALT: cpu_ce=0, cmd_ready=1.
- Command acceptance: cmd_ready=1 in HALT, RUN and STEP. A command accepted on edge k takes effect from cycle k+1; cpu_ce has no combinational dependence on cmd_*.
  - HALT: go to HALT; halted_on_bp=0.
  - RUN: go to RUN; halted_on_bp=0; arm skip_bp for the first RUN cycle.
  - STEP with cmd_steps=0: no-op, state unchanged.
  - STEP with cmd_steps=N>0: go to STEP, remaining=N; halted_on_bp=0.
  - CLEAR: go to RST_HOLD; zero both counters, flush the trace, clear overflow and halted_on_bp.
- cpu_ce is combinational from registered state and the PC compare:
  - RUN: cpu_ce = !(bp_en && cpu_pc==bp_addr && !skip_bp).
  - STEP: cpu_ce=1; STEP ignores the breakpoint.
  - Otherwise: cpu_ce=0.
- RUN, breakpoint hit (cpu_ce=0 due to the compare): next state HALT, halted_on_bp=1. The instruction at bp_addr is not executed. skip_bp clears after the first RUN cycle.
- STEP:
  - Each cycle decrements remaining.
  - On the edge where remaining goes 1→0, next state is HALT. Exactly N cpu_ce=1 cycles occur.
- A command accepted during RUN or STEP overrides the current activity on the same edge. The current cycle's cpu_ce still applies.
- cycle_count: +1 every edge with state≠RST_HOLD; saturates at all-ones.
- retired_count: +1 every edge with cpu_ce=1; saturates at all-ones.
- Trace write: on every edge with cpu_ce=1, write {cpu_pc, cpu_instruction} at the write pointer.
  - Not full: count+1.
  - Full without trace_rd: overwrite the oldest entry, advance both pointers, set trace_overflow.
- Trace read: trace_rd pops on the edge when not empty; trace_rd while empty is ignored.
- Simultaneous trace write and read:
  - Not empty: count unchanged, no overflow, even when full.
  - Empty: write only.
- Trace outputs are combinational reads at the read pointer; 0 when empty.
- Pointers wrap modulo TRACE_DEPTH.
- rst_n assertion mid-RUN/STEP: immediate asynchronous return to reset values, including cpu_ce=0.

Test Plan:
- Reset: rst_n low 3 cycles, then high → cpu_rst_n=0 for exactly 2 edges after release, then 1 with state=HALT, cycle_count=0, cpu_ce=0, trace_empty=1.
- Step: core PC increments by 4 from 0x0; STEP cmd_steps=3 → cpu_ce high exactly 3 cycles starting the cycle after acceptance, retired_count=3, state=HALT. Trace pops return PCs 0x0, 0x4, 0x8 in order, then trace_empty=1.
- Breakpoint: bp_en=1, bp_addr=0x10, RUN from PC 0x0 → retires 0x0–0xC, halts with cpu_pc=0x10, halted_on_bp=1, retired_count=4. A second RUN executes 0x10 (skip_bp); the PC reaches 0x14 with no halt.
- Overflow: TRACE_DEPTH=8, STEP 10 from PC 0 → trace_full=1, trace_overflow=1. Eight pops return PCs 0x08..0x24.
- Simultaneous read/write: trace_rd held during a STEP 8 run of the same full-trace sequence → count constant, overflow stays 0.
- Clear and async reset: CLEAR during RUN → next cycle state=RST_HOLD, cpu_rst_n=0 for 2 edges, counters 0, trace_empty=1. rst_n pulsed low mid-STEP → cpu_ce drops to 0 without waiting for a clock edge.
